// File: rtl/uart_mem_loader.sv
// Framed UART byte-stream loader: SYNC, ADDR, LEN, DATA, CSUM -> memory writes plus one ACK/NAK reply.
// A one-byte holding register decouples UART intake from the memory handshake.
module uart_mem_loader #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15,
    parameter int unsigned TIMEOUT_CLKS = 315000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        loading,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] ADDR_LO = 4'd1;
    localparam logic [3:0] ADDR_HI = 4'd2;
    localparam logic [3:0] LEN_LO  = 4'd3;
    localparam logic [3:0] LEN_HI  = 4'd4;
    localparam logic [3:0] DATA    = 4'd5;
    localparam logic [3:0] WRITE   = 4'd6;
    localparam logic [3:0] CSUM    = 4'd7;
    localparam logic [3:0] RESP    = 4'd8;

    logic [3:0]         state_q, state_d;
    logic [7:0]         hold_data;
    logic               hold_full;
    logic [15:0]        remain_q, remain_d;
    logic [7:0]         csum_q, csum_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        mem_addr_d;
    logic [7:0]         mem_wdata_d, tx_data_d;
    logic               mem_req_d, tx_start_d, loading_d, err_timeout_d, err_overrun_d;
    logic               consume_c, overrun_c, counting_c;

    assign consume_c  = hold_full && (state_q != WRITE) && (state_q != RESP);
    assign overrun_c  = rx_valid && hold_full && !consume_c;
    assign counting_c = (state_q == ADDR_LO) || (state_q == ADDR_HI) || (state_q == LEN_LO) ||
                        (state_q == LEN_HI)  || (state_q == DATA)    || (state_q == CSUM);

    // Holding register; an overrun discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (overrun_c) begin
            hold_full <= 1'b0;
        end else if (rx_valid) begin
            hold_data <= rx_data;
            hold_full <= 1'b1;
        end else if (consume_c) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            csum_q      <= '0;
            timer_q     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_req     <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            loading     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            csum_q      <= csum_d;
            timer_q     <= timer_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_req     <= mem_req_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            loading     <= loading_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        csum_d        = csum_q;
        timer_d       = timer_q;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_req_d     = mem_req;
        tx_data_d     = tx_data;
        tx_start_d    = 1'b0;
        loading_d     = loading;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        if (counting_c) timer_d = timer_q + TIMER_W'(1);
        if (rx_valid)   timer_d = '0;

        case (state_q)
            IDLE: begin
                if (consume_c && hold_data == SYNC_BYTE) begin
                    state_d   = ADDR_LO;
                    loading_d = 1'b1;
                    csum_d    = '0;
                end
            end
            ADDR_LO: if (consume_c) begin
                mem_addr_d[7:0] = hold_data;
                csum_d          = csum_q + hold_data;
                state_d         = ADDR_HI;
            end
            ADDR_HI: if (consume_c) begin
                mem_addr_d[15:8] = hold_data;
                csum_d           = csum_q + hold_data;
                state_d          = LEN_LO;
            end
            LEN_LO: if (consume_c) begin
                remain_d[7:0] = hold_data;
                csum_d        = csum_q + hold_data;
                state_d       = LEN_HI;
            end
            LEN_HI: if (consume_c) begin
                remain_d[15:8] = hold_data;
                csum_d         = csum_q + hold_data;
                state_d        = ({hold_data, remain_q[7:0]} == 16'd0) ? CSUM : DATA;
            end
            DATA: if (consume_c) begin
                mem_wdata_d = hold_data;
                mem_req_d   = 1'b1;
                csum_d      = csum_q + hold_data;
                state_d     = WRITE;
            end
            WRITE: if (mem_ack) begin
                mem_req_d  = 1'b0;
                mem_addr_d = mem_addr + 16'd1;
                remain_d   = remain_q - 16'd1;
                state_d    = (remain_q != 16'd1) ? DATA : CSUM;
            end
            CSUM: if (consume_c) begin
                tx_data_d = (hold_data == csum_q) ? ACK_BYTE : NAK_BYTE;
                state_d   = RESP;
            end
            RESP: if (!tx_busy) begin
                tx_start_d = 1'b1;
                loading_d  = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Aborts override the normal transition and suppress any response.
        if (counting_c && !rx_valid && timer_q == TIMER_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
            mem_req_d     = 1'b0;
            loading_d     = 1'b0;
            tx_start_d    = 1'b0;
        end
        if (overrun_c) begin
            err_overrun_d = 1'b1;
            state_d       = IDLE;
            mem_req_d     = 1'b0;
            loading_d     = 1'b0;
            tx_start_d    = 1'b0;
        end
        if (state_d == IDLE) timer_d = '0;
    end

endmodule
